// File: rtl/cam_match_encoder.sv
`default_nettype none
// ============================================================================
// Module   : cam_match_encoder
// Brief    : Turns a multi-hot CAM match vector into a stream of row indices,
//            lowest first, one per valid/ready handshake. Optional macro:
//            CAM_MULTI_MATCH_EN (emit every hit; otherwise priority-encode).
// Revision : 1.0 - initial release
// ============================================================================
module cam_match_encoder #(
    parameter int CAM_DEPTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  match_valid_i,
    input  logic [CAM_DEPTH-1:0]  match_vector_i,
    output logic                  match_ready_o,
    output logic                  addr_valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_last_o,
    input  logic                  addr_ready_i,
    output logic                  no_match_o,
    output logic [ADDR_WIDTH:0]   hit_count_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [CAM_DEPTH-1:0] c_ONE = CAM_DEPTH'(1);

    state_t                 state_q, state_d;
    logic [CAM_DEPTH-1:0]   pending_q, pending_d;
    logic [ADDR_WIDTH:0]    hit_count_q, hit_count_d;
    logic                   no_match_q, no_match_d;

    logic                   w_accept;
    logic [CAM_DEPTH-1:0]   w_rest;
    logic                   w_single;
    logic                   w_last;

    function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [CAM_DEPTH-1:0] v);
        logic [ADDR_WIDTH-1:0] idx;
        idx = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) idx = ADDR_WIDTH'(i);
        end
        return idx;
    endfunction

    function automatic logic [ADDR_WIDTH:0] popcount(input logic [CAM_DEPTH-1:0] v);
        logic [ADDR_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            cnt = cnt + (ADDR_WIDTH + 1)'(v[i]);
        end
        return cnt;
    endfunction

    // Clearing the lowest set bit yields the remaining hits; empty remainder means this is the last one.
    assign w_accept = match_valid_i && (state_q == ST_IDLE);
    assign w_rest   = pending_q & (pending_q - c_ONE);
    assign w_single = (pending_q != '0) && (w_rest == '0);

`ifdef CAM_MULTI_MATCH_EN
    assign w_last = (state_q == ST_EMIT) && w_single;
`else
    assign w_last = (state_q == ST_EMIT);
`endif

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hit_count_d = hit_count_q;
        no_match_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    pending_d   = match_vector_i;
                    hit_count_d = popcount(match_vector_i);
                    if (match_vector_i == '0) begin
                        no_match_d = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (addr_ready_i) begin
                    if (w_last) begin
                        pending_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        pending_d = w_rest;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            hit_count_q <= '0;
            no_match_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            hit_count_q <= hit_count_d;
            no_match_q  <= no_match_d;
        end
    end

    // pending is zero outside EMIT, so addr decodes to 0 whenever idle.
    assign match_ready_o = (state_q == ST_IDLE);
    assign addr_valid_o  = (state_q == ST_EMIT);
    assign addr_o        = lowest_index(pending_q);
    assign addr_last_o   = w_last;
    assign no_match_o    = no_match_q;
    assign hit_count_o   = hit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_match_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_match_encoder
// Brief    : Scoreboard bench for cam_match_encoder; expected indices are
//            queued on acceptance and compared on each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_match_encoder;

    localparam int CAM_DEPTH  = 8;
    localparam int ADDR_WIDTH = 3;
`ifdef CAM_MULTI_MATCH_EN
    localparam bit c_MULTI = 1'b1;
`else
    localparam bit c_MULTI = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  match_valid_i = 1'b0;
    logic [CAM_DEPTH-1:0]  match_vector_i = '0;
    logic                  match_ready_o;
    logic                  addr_valid_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  addr_last_o;
    logic                  addr_ready_i = 1'b1;
    logic                  no_match_o;
    logic [ADDR_WIDTH:0]   hit_count_o;

    int passed = 0;
    int total  = 0;

    exp_t              sb_q[$];
    logic [ADDR_WIDTH:0] exp_hit = '0;
    logic              exp_nm  = 1'b0;

    cam_match_encoder #(
        .CAM_DEPTH  (CAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .match_valid_i  (match_valid_i),
        .match_vector_i (match_vector_i),
        .match_ready_o  (match_ready_o),
        .addr_valid_o   (addr_valid_o),
        .addr_o         (addr_o),
        .addr_last_o    (addr_last_o),
        .addr_ready_i   (addr_ready_i),
        .no_match_o     (no_match_o),
        .hit_count_o    (hit_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: outputs are compared mid-cycle, then the upcoming edge is applied to the model.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_hit = '0;
            exp_nm  = 1'b0;
        end else begin
            bit model_ready;
            model_ready = (sb_q.size() == 0);
            chk("match_ready", 32'(match_ready_o), 32'(model_ready));
            chk("addr_valid",  32'(addr_valid_o),  32'(!model_ready));
            chk("no_match",    32'(no_match_o),    32'(exp_nm));
            chk("hit_count",   32'(hit_count_o),   32'(exp_hit));
            if (!model_ready) begin
                chk("addr",      32'(addr_o),      32'(sb_q[0].addr));
                chk("addr_last", 32'(addr_last_o), 32'(sb_q[0].last));
                if (addr_ready_i) void'(sb_q.pop_front());
            end
            exp_nm = 1'b0;
            if (match_valid_i && model_ready) begin
                logic [CAM_DEPTH-1:0] v;
                v       = match_vector_i;
                exp_hit = (ADDR_WIDTH + 1)'($countones(v));
                exp_nm  = (v == '0);
                for (int i = 0; i < CAM_DEPTH; i++) begin
                    if (v[i]) begin
                        exp_t e;
                        e.addr = ADDR_WIDTH'(i);
                        v[i]   = 1'b0;
                        e.last = !c_MULTI || (v == '0);
                        sb_q.push_back(e);
                        if (!c_MULTI) break;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a vector and returns one time unit after the edge that accepted it (valid left high).
    task automatic send(input logic [CAM_DEPTH-1:0] vec);
        bit got;
        got = 1'b0;
        match_valid_i  = 1'b1;
        match_vector_i = vec;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = match_ready_o;
            tick();
        end
        if (!got) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held in reset
        #2;
        chk("rst_addr_valid",  32'(addr_valid_o),  32'(0));
        chk("rst_match_ready", 32'(match_ready_o), 32'(1));
        chk("rst_hit_count",   32'(hit_count_o),   32'(0));
        chk("rst_no_match",    32'(no_match_o),    32'(0));
        chk("rst_addr",        32'(addr_o),        32'(0));
        chk("rst_addr_last",   32'(addr_last_o),   32'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: all-zero vector
        send(8'h00);
        match_valid_i = 1'b0;
        chk("t1_no_match", 32'(no_match_o), 32'(1));
        tick();
        chk("t1_no_match_pulse", 32'(no_match_o), 32'(0));
        tick();

        // 2 / 5: three hits, consumer always ready
        addr_ready_i = 1'b1;
        send(8'b1010_0100);
        match_valid_i = 1'b0;
        chk("t2_first_addr", 32'(addr_o),      32'(2));
        chk("t2_first_last", 32'(addr_last_o), 32'(!c_MULTI));
        chk("t2_hit_count",  32'(hit_count_o), 32'(3));
        repeat (5) tick();

        // 3: backpressure on first index
        addr_ready_i = 1'b0;
        send(8'b1000_0001);
        match_valid_i = 1'b0;
        repeat (3) tick();
        chk("t3_held_addr", 32'(addr_o),       32'(0));
        chk("t3_held_last", 32'(addr_last_o),  32'(!c_MULTI));
        chk("t3_held_vld",  32'(addr_valid_o), 32'(1));
        addr_ready_i = 1'b1;
        repeat (4) tick();

        // 4: asynchronous reset after first handshake
        send(8'b1111_0000);
        match_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t4_addr_valid",  32'(addr_valid_o),  32'(0));
        chk("t4_no_match",    32'(no_match_o),    32'(0));
        chk("t4_hit_count",   32'(hit_count_o),   32'(0));
        chk("t4_match_ready", 32'(match_ready_o), 32'(1));
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        send(8'h01);
        match_valid_i = 1'b0;
        chk("t4_new_addr", 32'(addr_o), 32'(0));
        repeat (3) tick();

        // 6: back-to-back vectors
        send(8'h80);
        chk("t6_addr7", 32'(addr_o),      32'(7));
        chk("t6_last7", 32'(addr_last_o), 32'(1));
        send(8'h02);
        match_valid_i = 1'b0;
        chk("t6_addr1", 32'(addr_o),      32'(1));
        chk("t6_hit1",  32'(hit_count_o), 32'(1));
        repeat (4) tick();

        // Full row under backpressure toggling
        match_vector_i = 8'hFF;
        send(8'hFF);
        match_valid_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            addr_ready_i = k[0];
            tick();
        end
        addr_ready_i = 1'b1;
        repeat (3) tick();
        chk("end_idle", 32'(match_ready_o), 32'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
